// File: rtl/cdb_arbiter.sv
// CDB arbiter: merges FU completions onto N_WAY registered broadcast lanes.
// Overflow completions wait in an in-order circular buffer; buffered work always drains first.
module cdb_arbiter #(
    parameter int N_WAY    = 3,
    parameter int N_FU     = 4,
    parameter int CDB_BITS = 6,
    parameter int XLEN     = 32,
    parameter int DEPTH    = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    input  logic [N_FU-1:0]                    fu_done_valid,
    input  logic [N_FU-1:0][CDB_BITS-1:0]      fu_done_tag,
    input  logic [N_FU-1:0][XLEN-1:0]          fu_done_value,
    output logic                               fu_done_ready,
    output logic [N_WAY-1:0]                   cdb_valid,
    output logic [N_WAY-1:0][CDB_BITS-1:0]     cdb_rs_reg_idx,
    output logic [N_WAY-1:0][XLEN-1:0]         cdb_value,
    output logic [$clog2(DEPTH):0]             buf_count,
    output logic                               tag0_err
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    // Worst-case growth per edge is N_FU - N_WAY, so this threshold keeps the buffer from overflowing.
    localparam int THR = (DEPTH - N_FU + N_WAY > DEPTH) ? DEPTH : DEPTH - N_FU + N_WAY;

    logic [CDB_BITS-1:0]                r_buf_tag [DEPTH];
    logic [XLEN-1:0]                    r_buf_val [DEPTH];
    logic [PW-1:0]                      r_head, r_tail;
    logic [CW-1:0]                      r_count;
    logic [N_WAY-1:0]                   r_cdb_vld;
    logic [N_WAY-1:0][CDB_BITS-1:0]     r_cdb_tag;
    logic [N_WAY-1:0][XLEN-1:0]         r_cdb_val;
    logic                               r_tag0;

    logic                               w_ready;
    logic                               w_tag0;
    logic [N_FU-1:0]                    w_acc;
    int                                 w_rank [N_FU];
    int                                 w_n_pop, w_n_acc, w_n_push;
    logic [N_FU-1:0]                    w_push_en;
    logic [N_FU-1:0][PW-1:0]            w_push_idx;
    logic [N_WAY-1:0]                   w_lane_vld;
    logic [N_WAY-1:0][CDB_BITS-1:0]     w_lane_tag;
    logic [N_WAY-1:0][XLEN-1:0]         w_lane_val;

    assign w_ready = (int'(r_count) <= THR);

    always_comb begin
        w_n_pop    = (int'(r_count) < N_WAY) ? int'(r_count) : N_WAY;
        w_n_acc    = 0;
        w_tag0     = 1'b0;
        w_acc      = '0;
        w_push_en  = '0;
        w_push_idx = '0;
        w_lane_vld = '0;
        w_lane_tag = '0;
        w_lane_val = '0;
        for (int i = 0; i < N_FU; i++) begin
            w_rank[i] = w_n_acc;
            w_acc[i]  = fu_done_valid[i] && w_ready && (fu_done_tag[i] != '0);
            if (w_acc[i])
                w_n_acc = w_n_acc + 1;
            if (fu_done_valid[i] && w_ready && (fu_done_tag[i] == '0))
                w_tag0 = 1'b1;
        end
        w_n_push = (w_n_acc > N_WAY - w_n_pop) ? w_n_acc - (N_WAY - w_n_pop) : 0;
        // Lanes fill with the oldest buffered entries, then new completions in FU order.
        for (int l = 0; l < N_WAY; l++) begin
            if (l < w_n_pop) begin
                w_lane_vld[l] = 1'b1;
                w_lane_tag[l] = r_buf_tag[PW'((int'(r_head) + l) % DEPTH)];
                w_lane_val[l] = r_buf_val[PW'((int'(r_head) + l) % DEPTH)];
            end
            for (int i = 0; i < N_FU; i++) begin
                if (w_acc[i] && (w_n_pop + w_rank[i] == l)) begin
                    w_lane_vld[l] = 1'b1;
                    w_lane_tag[l] = fu_done_tag[i];
                    w_lane_val[l] = fu_done_value[i];
                end
            end
        end
        for (int i = 0; i < N_FU; i++) begin
            if (w_acc[i] && (w_n_pop + w_rank[i] >= N_WAY)) begin
                w_push_en[i]  = 1'b1;
                w_push_idx[i] = PW'((int'(r_tail) + w_rank[i] - (N_WAY - w_n_pop)) % DEPTH);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_cdb_vld <= '0;
            r_cdb_tag <= '0;
            r_cdb_val <= '0;
            r_tag0    <= 1'b0;
        end else begin
            r_tag0 <= r_tag0 | w_tag0;
            if (flush) begin
                r_head    <= '0;
                r_tail    <= '0;
                r_count   <= '0;
                r_cdb_vld <= '0;
                r_cdb_tag <= '0;
                r_cdb_val <= '0;
            end else begin
                r_head    <= PW'((int'(r_head) + w_n_pop) % DEPTH);
                r_tail    <= PW'((int'(r_tail) + w_n_push) % DEPTH);
                r_count   <= CW'(int'(r_count) - w_n_pop + w_n_push);
                r_cdb_vld <= w_lane_vld;
                r_cdb_tag <= w_lane_tag;
                r_cdb_val <= w_lane_val;
            end
        end
    end

    // Payload storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clock) begin
        if (!flush) begin
            for (int i = 0; i < N_FU; i++) begin
                if (w_push_en[i]) begin
                    r_buf_tag[w_push_idx[i]] <= fu_done_tag[i];
                    r_buf_val[w_push_idx[i]] <= fu_done_value[i];
                end
            end
        end
    end

    assign fu_done_ready  = w_ready;
    assign cdb_valid      = r_cdb_vld;
    assign cdb_rs_reg_idx = r_cdb_tag;
    assign cdb_value      = r_cdb_val;
    assign buf_count      = r_count;
    assign tag0_err       = r_tag0;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic checked against a queue model.
module tb_cdb_arbiter;
    localparam int NW  = 3;
    localparam int NF  = 4;
    localparam int CB  = 6;
    localparam int XL  = 32;
    localparam int D   = 8;
    localparam int THR = (D - NF + NW > D) ? D : D - NF + NW;

    logic                      clock, reset, flush;
    logic [NF-1:0]             fu_done_valid;
    logic [NF-1:0][CB-1:0]     fu_done_tag;
    logic [NF-1:0][XL-1:0]     fu_done_value;
    logic                      fu_done_ready;
    logic [NW-1:0]             cdb_valid;
    logic [NW-1:0][CB-1:0]     cdb_rs_reg_idx;
    logic [NW-1:0][XL-1:0]     cdb_value;
    logic [$clog2(D):0]        buf_count;
    logic                      tag0_err;

    cdb_arbiter #(.N_WAY(NW), .N_FU(NF), .CDB_BITS(CB), .XLEN(XL), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .fu_done_valid(fu_done_valid), .fu_done_tag(fu_done_tag), .fu_done_value(fu_done_value),
        .fu_done_ready(fu_done_ready), .cdb_valid(cdb_valid), .cdb_rs_reg_idx(cdb_rs_reg_idx),
        .cdb_value(cdb_value), .buf_count(buf_count), .tag0_err(tag0_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a FIFO of pending completions plus the expected lane contents.
    logic [CB-1:0] mq_tag [$];
    logic [XL-1:0] mq_val [$];
    logic          ev  [NW];
    logic [CB-1:0] et  [NW];
    logic [XL-1:0] evl [NW];
    bit            m_tag0;

    task automatic model_reset();
        mq_tag.delete();
        mq_val.delete();
        m_tag0 = 1'b0;
        for (int l = 0; l < NW; l++) begin
            ev[l] = 1'b0; et[l] = '0; evl[l] = '0;
        end
    endtask

    task automatic clr_fu();
        fu_done_valid = '0;
        fu_done_tag   = '0;
        fu_done_value = '0;
    endtask

    task automatic set_fu(input int i, input int tag, input logic [XL-1:0] val);
        fu_done_valid[i] = 1'b1;
        fu_done_tag[i]   = CB'(tag);
        fu_done_value[i] = val;
    endtask

    // Advance one edge, updating the model from the inputs present before it.
    task automatic step();
        logic [CB-1:0] ct [$];
        logic [XL-1:0] cv [$];
        bit rdy;
        rdy = (mq_tag.size() <= THR);
        for (int i = 0; i < NF; i++)
            if (fu_done_valid[i] && rdy && fu_done_tag[i] == '0) m_tag0 = 1'b1;
        if (!flush) begin
            ct = mq_tag;
            cv = mq_val;
            for (int i = 0; i < NF; i++)
                if (fu_done_valid[i] && rdy && fu_done_tag[i] != '0) begin
                    ct.push_back(fu_done_tag[i]);
                    cv.push_back(fu_done_value[i]);
                end
        end
        for (int l = 0; l < NW; l++) begin
            if (ct.size() > 0) begin
                ev[l] = 1'b1; et[l] = ct.pop_front(); evl[l] = cv.pop_front();
            end else begin
                ev[l] = 1'b0; et[l] = '0; evl[l] = '0;
            end
        end
        mq_tag = ct;
        mq_val = cv;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < NF; i++) set_fu(i, 10 + i, 32'hDEAD0000 + i);
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if (cdb_valid !== '0 || cdb_rs_reg_idx !== '0 || cdb_value !== '0) begin
            n_fail++;
            $display("FAIL reset_lanes: got v=%b tags=%h, want all zero", cdb_valid, cdb_rs_reg_idx);
        end
        n_cmp++;
        if (buf_count !== 0 || fu_done_ready !== 1'b1 || tag0_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got cnt=%0d rdy=%b t0=%b, want 0 1 0", buf_count, fu_done_ready, tag0_err);
        end
        @(negedge clock);
        clr_fu();
        reset = 1'b1;
        model_reset();
        step();
        n_cmp++;
        if (cdb_valid !== '0 || cdb_rs_reg_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b tags=%h, want idle tag 0", cdb_valid, cdb_rs_reg_idx);
        end
    endtask

    task automatic test_single();
        set_fu(2, 33, 32'hAB);
        step();
        clr_fu();
        n_cmp++;
        if (cdb_valid !== 3'b001 || cdb_rs_reg_idx[0] !== 6'd33 || cdb_value[0] !== 32'hAB ||
            cdb_rs_reg_idx[1] !== '0 || cdb_rs_reg_idx[2] !== '0 || buf_count !== 0) begin
            n_fail++;
            $display("FAIL single: got v=%b t0=%0d val=%h t1=%0d t2=%0d cnt=%0d, want 001 33 ab 0 0 0",
                     cdb_valid, cdb_rs_reg_idx[0], cdb_value[0], cdb_rs_reg_idx[1], cdb_rs_reg_idx[2], buf_count);
        end
        step();
        n_cmp++;
        if (cdb_valid !== '0 || cdb_rs_reg_idx[0] !== '0) begin
            n_fail++;
            $display("FAIL single_oneshot: got v=%b t0=%0d, want 000 0", cdb_valid, cdb_rs_reg_idx[0]);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < NF; i++) set_fu(i, 33 + i, 32'h100 + i);
        step();
        clr_fu();
        n_cmp++;
        if (cdb_valid !== 3'b111 || cdb_rs_reg_idx[0] !== 6'd33 || cdb_rs_reg_idx[1] !== 6'd34 ||
            cdb_rs_reg_idx[2] !== 6'd35 || buf_count !== 1) begin
            n_fail++;
            $display("FAIL overflow_c1: got v=%b tags=%0d/%0d/%0d cnt=%0d, want 111 33/34/35 1",
                     cdb_valid, cdb_rs_reg_idx[0], cdb_rs_reg_idx[1], cdb_rs_reg_idx[2], buf_count);
        end
        step();
        n_cmp++;
        if (cdb_valid !== 3'b001 || cdb_rs_reg_idx[0] !== 6'd36 || cdb_value[0] !== 32'h103 || buf_count !== 0) begin
            n_fail++;
            $display("FAIL overflow_c2: got v=%b t0=%0d val=%h cnt=%0d, want 001 36 103 0",
                     cdb_valid, cdb_rs_reg_idx[0], cdb_value[0], buf_count);
        end
    endtask

    task automatic test_back_pressure();
        int got [$];
        bit order_ok;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NF; i++) set_fu(i, c * 4 + i + 1, $urandom);
            step();
            for (int l = 0; l < NW; l++) if (cdb_valid[l]) got.push_back(int'(cdb_rs_reg_idx[l]));
            n_cmp++;
            if (buf_count !== c + 1) begin
                n_fail++;
                $display("FAIL bp_count c%0d: got %0d, want %0d", c, buf_count, c + 1);
            end
        end
        n_cmp++;
        if (fu_done_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_low: got %b, want 0", fu_done_ready);
        end
        // These are presented while not ready and must be ignored.
        for (int i = 0; i < NF; i++) set_fu(i, 50 + i, 32'h5);
        step();
        clr_fu();
        for (int l = 0; l < NW; l++) if (cdb_valid[l]) got.push_back(int'(cdb_rs_reg_idx[l]));
        n_cmp++;
        if (fu_done_ready !== 1'b1 || buf_count !== 5) begin
            n_fail++;
            $display("FAIL bp_drain: got rdy=%b cnt=%0d, want 1 5", fu_done_ready, buf_count);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            for (int l = 0; l < NW; l++) if (cdb_valid[l]) got.push_back(int'(cdb_rs_reg_idx[l]));
        end
        order_ok = (got.size() == 32);
        for (int j = 0; j < got.size() && j < 32; j++) if (got[j] != j + 1) order_ok = 1'b0;
        n_cmp++;
        if (!order_ok || buf_count !== 0) begin
            n_fail++;
            $display("FAIL bp_order: got %0d tags (first %0d) cnt=%0d, want 32 tags 1..32 in order cnt=0",
                     got.size(), (got.size() > 0) ? got[0] : -1, buf_count);
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < NF; i++) set_fu(i, c * 4 + i + 1, $urandom);
            step();
        end
        clr_fu();
        n_cmp++;
        if (buf_count !== 5) begin
            n_fail++;
            $display("FAIL flush_pre: got cnt=%0d, want 5", buf_count);
        end
        for (int i = 0; i < 3; i++) set_fu(i, 21 + i, $urandom);
        flush = 1'b1;
        step();
        flush = 1'b0;
        clr_fu();
        n_cmp++;
        if (cdb_valid !== '0 || cdb_rs_reg_idx !== '0 || buf_count !== 0 || fu_done_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_edge: got v=%b tags=%h cnt=%0d rdy=%b, want idle 0 1",
                     cdb_valid, cdb_rs_reg_idx, buf_count, fu_done_ready);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (cdb_valid !== '0) begin
                n_fail++;
                $display("FAIL flush_leak k%0d: got v=%b tag0=%0d, want no broadcast", k, cdb_valid, cdb_rs_reg_idx[0]);
            end
        end
    endtask

    task automatic test_tag0();
        set_fu(0, 0, 32'h11);
        set_fu(1, 40, 32'h40);
        step();
        clr_fu();
        n_cmp++;
        if (cdb_valid !== 3'b001 || cdb_rs_reg_idx[0] !== 6'd40 || cdb_value[0] !== 32'h40 || tag0_err !== 1'b1) begin
            n_fail++;
            $display("FAIL tag0_drop: got v=%b t0=%0d val=%h err=%b, want 001 40 40 1",
                     cdb_valid, cdb_rs_reg_idx[0], cdb_value[0], tag0_err);
        end
        for (int k = 0; k < 3; k++) begin
            set_fu(3, 7 + k, $urandom);
            flush = (k == 2);
            step();
            flush = 1'b0;
            clr_fu();
            n_cmp++;
            if (tag0_err !== 1'b1) begin
                n_fail++;
                $display("FAIL tag0_sticky k%0d: got %b, want 1", k, tag0_err);
            end
        end
        for (int i = 0; i < NF; i++) set_fu(i, 60 + i, $urandom);
        step();
        clr_fu();
        // Asynchronous reset mid-cycle, away from any clock edge.
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (tag0_err !== 1'b0 || buf_count !== 0 || cdb_valid !== '0 || fu_done_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got err=%b cnt=%0d v=%b rdy=%b, want 0 0 000 1",
                     tag0_err, buf_count, cdb_valid, fu_done_ready);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 99) < 4);
            for (int i = 0; i < NF; i++) begin
                fu_done_valid[i] = ($urandom_range(0, 99) < 55);
                fu_done_tag[i]   = CB'($urandom_range(1, 63));
                if (!flush && $urandom_range(0, 99) < 2) fu_done_tag[i] = '0;
                fu_done_value[i] = $urandom;
            end
            step();
            for (int l = 0; l < NW; l++) begin
                n_cmp++;
                if (cdb_valid[l] !== ev[l] || cdb_rs_reg_idx[l] !== et[l] || cdb_value[l] !== evl[l]) begin
                    n_fail++;
                    $display("FAIL rand_lane%0d cyc%0d: got v=%b t=%0d val=%h, want v=%b t=%0d val=%h",
                             l, c, cdb_valid[l], cdb_rs_reg_idx[l], cdb_value[l], ev[l], et[l], evl[l]);
                end
            end
            n_cmp++;
            if (int'(buf_count) != mq_tag.size() || fu_done_ready !== (mq_tag.size() <= THR) || tag0_err !== m_tag0) begin
                n_fail++;
                $display("FAIL rand_status cyc%0d: got cnt=%0d rdy=%b err=%b, want %0d %b %b",
                         c, buf_count, fu_done_ready, tag0_err, mq_tag.size(), (mq_tag.size() <= THR), m_tag0);
            end
        end
        flush = 1'b0;
        clr_fu();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        clr_fu();
        test_reset();
        test_single();
        test_overflow();
        test_back_pressure();
        test_flush();
        test_tag0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
